id_ctrl_pipe: RTL and testbench

Registered decode-stage control unit for the MIPS pipeline. It decodes the 32-bit instruction in ID into the control bundle consumed by EX/MEM/WB. Over the combinational decoder it adds:
- full load/store/branch/jump/arith-immediate coverage;
- a reserved-instruction flag;
- a valid/ready handshake into a one-entry ID/EX control register with flush;
- a HI/LO busy counter that stalls HI/LO accesses while a multi-cycle mult/div is in flight.

---
 rtl/id_ctrl_pipe_pkg.sv | 80 ++++++++
 rtl/id_ctrl_decode.sv | 117 +++++++++++
 rtl/id_ctrl_pipe.sv | 102 ++++++++++
 tb/tb_id_ctrl_pipe.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ctrl_pipe_pkg.sv
// Shared decode constants for the ID-stage control unit: opcode/funct/REGIMM
// codes, control-bundle bit positions and reg_dst selector codes.
package id_ctrl_pipe_pkg;

  localparam int CTRL_W = 9;

  // ctrl = {jump,branch,alu_src,mem_read,mem_write,mem_to_reg,reg_write,reg_dst[1:0]}
  localparam int B_JUMP       = 8;
  localparam int B_BRANCH     = 7;
  localparam int B_ALU_SRC    = 6;
  localparam int B_MEM_READ   = 5;
  localparam int B_MEM_WRITE  = 4;
  localparam int B_MEM_TO_REG = 3;
  localparam int B_REG_WRITE  = 2;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [CTRL_W-1:0] CTRL_RTYPE = 9'b000000101;
  localparam logic [CTRL_W-1:0] CTRL_ALUI  = 9'b001000100;

  // Opcodes
  localparam logic [5:0] EXE_SPECIAL = 6'b000000;
  localparam logic [5:0] EXE_REGIMM  = 6'b000001;
  localparam logic [5:0] EXE_J       = 6'b000010;
  localparam logic [5:0] EXE_JAL     = 6'b000011;
  localparam logic [5:0] EXE_BEQ     = 6'b000100;
  localparam logic [5:0] EXE_BNE     = 6'b000101;
  localparam logic [5:0] EXE_BLEZ    = 6'b000110;
  localparam logic [5:0] EXE_BGTZ    = 6'b000111;
  localparam logic [5:0] EXE_ADDI    = 6'b001000;
  localparam logic [5:0] EXE_ADDIU   = 6'b001001;
  localparam logic [5:0] EXE_SLTI    = 6'b001010;
  localparam logic [5:0] EXE_SLTIU   = 6'b001011;
  localparam logic [5:0] EXE_ANDI    = 6'b001100;
  localparam logic [5:0] EXE_ORI     = 6'b001101;
  localparam logic [5:0] EXE_XORI    = 6'b001110;
  localparam logic [5:0] EXE_LUI     = 6'b001111;
  localparam logic [5:0] EXE_LB      = 6'b100000;
  localparam logic [5:0] EXE_LH      = 6'b100001;
  localparam logic [5:0] EXE_LW      = 6'b100011;
  localparam logic [5:0] EXE_LBU     = 6'b100100;
  localparam logic [5:0] EXE_LHU     = 6'b100101;
  localparam logic [5:0] EXE_SB      = 6'b101000;
  localparam logic [5:0] EXE_SH      = 6'b101001;
  localparam logic [5:0] EXE_SW      = 6'b101011;

  // SPECIAL funct codes
  localparam logic [5:0] EXE_SLL   = 6'b000000;
  localparam logic [5:0] EXE_SRL   = 6'b000010;
  localparam logic [5:0] EXE_SRA   = 6'b000011;
  localparam logic [5:0] EXE_SLLV  = 6'b000100;
  localparam logic [5:0] EXE_SRLV  = 6'b000110;
  localparam logic [5:0] EXE_SRAV  = 6'b000111;
  localparam logic [5:0] EXE_JR    = 6'b001000;
  localparam logic [5:0] EXE_MFHI  = 6'b010000;
  localparam logic [5:0] EXE_MTHI  = 6'b010001;
  localparam logic [5:0] EXE_MFLO  = 6'b010010;
  localparam logic [5:0] EXE_MTLO  = 6'b010011;
  localparam logic [5:0] EXE_MULT  = 6'b011000;
  localparam logic [5:0] EXE_MULTU = 6'b011001;
  localparam logic [5:0] EXE_DIV   = 6'b011010;
  localparam logic [5:0] EXE_DIVU  = 6'b011011;
  localparam logic [5:0] EXE_ADD   = 6'b100000;
  localparam logic [5:0] EXE_ADDU  = 6'b100001;
  localparam logic [5:0] EXE_SUB   = 6'b100010;
  localparam logic [5:0] EXE_SUBU  = 6'b100011;
  localparam logic [5:0] EXE_AND   = 6'b100100;
  localparam logic [5:0] EXE_OR    = 6'b100101;
  localparam logic [5:0] EXE_XOR   = 6'b100110;
  localparam logic [5:0] EXE_NOR   = 6'b100111;
  localparam logic [5:0] EXE_SLT   = 6'b101010;
  localparam logic [5:0] EXE_SLTU  = 6'b101011;

  // REGIMM rt codes
  localparam logic [4:0] EXE_BLTZ = 5'b00000;
  localparam logic [4:0] EXE_BGEZ = 5'b00001;

endpackage

// File: rtl/id_ctrl_decode.sv
// Purely combinational instruction decoder producing the ID/EX control bundle
// plus mult/div class flags used by the parent's HI/LO busy counter.
module id_ctrl_decode
  import id_ctrl_pipe_pkg::*;
#(
  parameter int EN_MEMBR = 1
) (
  input  logic [5:0]        op,
  input  logic [4:0]        rt,
  input  logic [5:0]        funct,
  output logic [CTRL_W-1:0] ctrl,
  output logic              sign_ext,
  output logic              hilo_we,
  output logic              hilo_re,
  output logic              ri,
  output logic              mul_op,
  output logic              div_op
);

  // Set for load/store/branch/jump classes so they can be demoted to reserved.
  logic membr;

  always_comb begin
    ctrl     = '0;
    sign_ext = 1'b0;
    hilo_we  = 1'b0;
    hilo_re  = 1'b0;
    ri       = 1'b0;
    mul_op   = 1'b0;
    div_op   = 1'b0;
    membr    = 1'b0;

    case (op)
      EXE_SPECIAL: begin
        case (funct)
          EXE_SLL, EXE_SRL, EXE_SRA, EXE_SLLV, EXE_SRLV, EXE_SRAV,
          EXE_AND, EXE_OR, EXE_XOR, EXE_NOR,
          EXE_ADD, EXE_ADDU, EXE_SUB, EXE_SUBU, EXE_SLT, EXE_SLTU:
            ctrl = CTRL_RTYPE;
          EXE_MFHI, EXE_MFLO: begin
            ctrl    = CTRL_RTYPE;
            hilo_re = 1'b1;
          end
          EXE_MTHI, EXE_MTLO:
            hilo_we = 1'b1;
          EXE_MULT, EXE_MULTU: begin
            hilo_we = 1'b1;
            mul_op  = 1'b1;
          end
          EXE_DIV, EXE_DIVU: begin
            hilo_we = 1'b1;
            div_op  = 1'b1;
          end
          EXE_JR: begin
            ctrl[B_JUMP] = 1'b1;
            membr        = 1'b1;
          end
          default: ri = 1'b1;
        endcase
      end
      EXE_REGIMM: begin
        if (rt == EXE_BLTZ || rt == EXE_BGEZ) begin
          ctrl[B_BRANCH] = 1'b1;
          sign_ext       = 1'b1;
          membr          = 1'b1;
        end else begin
          ri = 1'b1;
        end
      end
      EXE_ANDI, EXE_ORI, EXE_XORI, EXE_LUI:
        ctrl = CTRL_ALUI;
      EXE_ADDI, EXE_ADDIU, EXE_SLTI, EXE_SLTIU: begin
        ctrl     = CTRL_ALUI;
        sign_ext = 1'b1;
      end
      EXE_LB, EXE_LBU, EXE_LH, EXE_LHU, EXE_LW: begin
        ctrl[B_ALU_SRC]    = 1'b1;
        ctrl[B_MEM_READ]   = 1'b1;
        ctrl[B_MEM_TO_REG] = 1'b1;
        ctrl[B_REG_WRITE]  = 1'b1;
        ctrl[1:0]          = RD_RT;
        sign_ext           = 1'b1;
        membr              = 1'b1;
      end
      EXE_SB, EXE_SH, EXE_SW: begin
        ctrl[B_ALU_SRC]   = 1'b1;
        ctrl[B_MEM_WRITE] = 1'b1;
        sign_ext          = 1'b1;
        membr             = 1'b1;
      end
      EXE_BEQ, EXE_BNE, EXE_BGTZ, EXE_BLEZ: begin
        ctrl[B_BRANCH] = 1'b1;
        sign_ext       = 1'b1;
        membr          = 1'b1;
      end
      EXE_J: begin
        ctrl[B_JUMP] = 1'b1;
        membr        = 1'b1;
      end
      EXE_JAL: begin
        ctrl[B_JUMP]      = 1'b1;
        ctrl[B_REG_WRITE] = 1'b1;
        ctrl[1:0]         = RD_RA;
        membr             = 1'b1;
      end
      default: ri = 1'b1;
    endcase

    // ALU-only bring-up cores trap everything that touches memory or the PC.
    if (membr && EN_MEMBR == 0) begin
      ctrl     = '0;
      sign_ext = 1'b0;
      ri       = 1'b1;
    end
  end

endmodule

// File: rtl/id_ctrl_pipe.sv
// Registered decode-stage control unit: decoder + one-entry ID/EX control
// register with valid/ready handshake, flush, and a HI/LO busy interlock.
module id_ctrl_pipe
  import id_ctrl_pipe_pkg::*;
#(
  parameter int MUL_LAT  = 2,
  parameter int DIV_LAT  = 32,
  parameter int EN_MEMBR = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [8:0]  ctrl,
  output logic        sign_ext,
  output logic        hilo_we,
  output logic        hilo_re,
  output logic        ri,
  output logic        hilo_busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_sign_ext;
  logic              dec_hilo_we;
  logic              dec_hilo_re;
  logic              dec_ri;
  logic              dec_mul;
  logic              dec_div;
  logic [CNT_W-1:0]  cnt;
  logic              hazard;
  logic              fire;

  // rs, rd, shamt and imm16 do not influence control.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[25:21], instr[15:6]};

  id_ctrl_decode #(
    .EN_MEMBR(EN_MEMBR)
  ) u_decode (
    .op      (instr[31:26]),
    .rt      (instr[20:16]),
    .funct   (instr[5:0]),
    .ctrl    (dec_ctrl),
    .sign_ext(dec_sign_ext),
    .hilo_we (dec_hilo_we),
    .hilo_re (dec_hilo_re),
    .ri      (dec_ri),
    .mul_op  (dec_mul),
    .div_op  (dec_div)
  );

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready never depends on in_valid; out_valid, once set, holds
  // the bundle unchanged until out_ready is seen (or flush kills it).
  assign hilo_busy = (cnt != '0);
  assign hazard    = (dec_hilo_we | dec_hilo_re) & hilo_busy;
  assign in_ready  = (~out_valid | out_ready) & ~hazard;
  assign fire      = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      ctrl      <= '0;
      sign_ext  <= 1'b0;
      hilo_we   <= 1'b0;
      hilo_re   <= 1'b0;
      ri        <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid <= 1'b1;
      ctrl      <= dec_ctrl;
      sign_ext  <= dec_sign_ext;
      hilo_we   <= dec_hilo_we;
      hilo_re   <= dec_hilo_re;
      ri        <= dec_ri;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Flush leaves the counter alone: the external mul/div keeps running.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (fire && dec_mul) begin
      cnt <= CNT_W'(MUL_LAT);
    end else if (fire && dec_div) begin
      cnt <= CNT_W'(DIV_LAT);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Directed bench for id_ctrl_pipe: decode classes, handshake/backpressure,
// flush, HI/LO busy interlock timing and async reset.
module tb_id_ctrl_pipe;

  localparam logic [31:0] I_ORI   = 32'h34010005;
  localparam logic [31:0] I_LW    = 32'h8C220004;
  localparam logic [31:0] I_JAL   = 32'h0C000000;
  localparam logic [31:0] I_MULT  = 32'h00220018;
  localparam logic [31:0] I_MFHI  = 32'h00002010;
  localparam logic [31:0] I_AND   = 32'h00221824;
  localparam logic [31:0] I_DIV   = 32'h0022001A;
  localparam logic [31:0] I_MTHI  = 32'h00200011;

  // clock / reset
  logic clk;
  logic resetn;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  ctrl;
  logic        sign_ext;
  logic        hilo_we;
  logic        hilo_re;
  logic        ri;
  logic        hilo_busy;

  logic        nm_out_valid;
  logic [8:0]  nm_ctrl;
  logic        nm_sign_ext;
  logic        nm_ri;
  logic        nm_unused_in_ready;
  logic        nm_unused_hilo_we;
  logic        nm_unused_hilo_re;
  logic        nm_unused_hilo_busy;

  id_ctrl_pipe #(.MUL_LAT(2), .DIV_LAT(32), .EN_MEMBR(1)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .instr    (instr),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ctrl     (ctrl),
    .sign_ext (sign_ext),
    .hilo_we  (hilo_we),
    .hilo_re  (hilo_re),
    .ri       (ri),
    .hilo_busy(hilo_busy)
  );

  id_ctrl_pipe #(.MUL_LAT(2), .DIV_LAT(32), .EN_MEMBR(0)) dut_nm (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (nm_unused_in_ready),
    .instr    (instr),
    .flush    (flush),
    .out_valid(nm_out_valid),
    .out_ready(out_ready),
    .ctrl     (nm_ctrl),
    .sign_ext (nm_sign_ext),
    .hilo_we  (nm_unused_hilo_we),
    .hilo_re  (nm_unused_hilo_re),
    .ri       (nm_ri),
    .hilo_busy(nm_unused_hilo_busy)
  );

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [10:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w);
    in_valid = v;
    instr    = w;
    #1;
  endtask

  // stream table: {ri, sign_ext, ctrl}
  localparam int N_STREAM = 8;
  logic [31:0] s_instr [N_STREAM];
  logic [10:0] s_exp   [N_STREAM];

  initial begin
    int busy_cycles;
    int idx;
    logic leak;

    s_instr[0] = I_AND;        s_exp[0] = 11'h005;
    s_instr[1] = I_ORI;        s_exp[1] = 11'h044;
    s_instr[2] = 32'h24010001; s_exp[2] = 11'h244;
    s_instr[3] = I_LW;         s_exp[3] = 11'h26C;
    s_instr[4] = 32'hAC220000; s_exp[4] = 11'h250;
    s_instr[5] = 32'h10220001; s_exp[5] = 11'h280;
    s_instr[6] = 32'h08000000; s_exp[6] = 11'h100;
    s_instr[7] = 32'hFC000000; s_exp[7] = 11'h400;

    in_valid  = 1'b0;
    instr     = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    resetn    = 1'b1;
    #1 resetn = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_ctrl",      32'(ctrl), 0);
    check("rst_sign_ext",  32'(sign_ext), 0);
    check("rst_hilo",      32'({hilo_we, hilo_re}), 0);
    check("rst_ri",        32'(ri), 0);
    check("rst_busy",      32'(hilo_busy), 0);
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // ori: one-cycle latency then drain
    drive(1'b1, I_ORI);
    check("ori_in_ready", 32'(in_ready), 1);
    tick();
    drive(1'b0, I_ORI);
    check("ori_valid", 32'(out_valid), 1);
    check("ori_ctrl",  32'(ctrl), 32'h044);
    check("ori_sext",  32'(sign_ext), 0);
    check("ori_ri",    32'(ri), 0);
    tick();
    check("ori_drain", 32'(out_valid), 0);

    // lw then jal, with and without mem/branch decode
    drive(1'b1, I_LW);
    tick();
    check("lw_ctrl",    32'(ctrl), 32'h06C);
    check("lw_sext",    32'(sign_ext), 1);
    check("lw_ri",      32'(ri), 0);
    check("nm_lw_valid", 32'(nm_out_valid), 1);
    check("nm_lw_ri",   32'(nm_ri), 1);
    check("nm_lw_ctrl", 32'({nm_sign_ext, nm_ctrl}), 0);
    drive(1'b1, I_JAL);
    tick();
    check("jal_ctrl",    32'(ctrl), 32'h106);
    check("jal_ri",      32'(ri), 0);
    check("nm_jal_ri",   32'(nm_ri), 1);
    check("nm_jal_ctrl", 32'(nm_ctrl), 0);
    drive(1'b0, I_JAL);
    tick();

    // mult then mfhi: mfhi blocked for exactly MUL_LAT cycles
    drive(1'b1, I_MULT);
    check("mult_in_ready", 32'(in_ready), 1);
    tick();
    check("mult_hilo_we", 32'(hilo_we), 1);
    check("mult_ctrl",    32'(ctrl), 0);
    check("mult_busy",    32'(hilo_busy), 1);
    drive(1'b1, I_MFHI);
    check("mfhi_stall_t1", 32'(in_ready), 0);
    tick();
    check("mfhi_stall_t2", 32'(in_ready), 0);
    tick();
    check("mfhi_ready_t3", 32'(in_ready), 1);
    check("mult_busy_off", 32'(hilo_busy), 0);
    tick();
    check("mfhi_valid", 32'(out_valid), 1);
    check("mfhi_re",    32'(hilo_re), 1);
    check("mfhi_ctrl",  32'(ctrl), 32'h005);
    drive(1'b0, I_MFHI);
    tick();

    // mult then an unrelated ALU op: never stalled
    drive(1'b1, I_MULT);
    tick();
    drive(1'b1, I_AND);
    check("and_no_stall", 32'(in_ready), 1);
    tick();
    check("and_ctrl",    32'(ctrl), 32'h005);
    check("and_hilo_re", 32'(hilo_re), 0);
    check("and_busy",    32'(hilo_busy), 1);
    drive(1'b0, I_AND);
    tick();
    check("and_busy_off", 32'(hilo_busy), 0);

    // flush with in_valid: instruction dropped, counter not loaded
    flush = 1'b1;
    drive(1'b1, I_MULT);
    tick();
    flush = 1'b0;
    drive(1'b0, I_MULT);
    check("flush_drop_valid", 32'(out_valid), 0);
    check("flush_drop_busy",  32'(hilo_busy), 0);

    // div, flush next cycle: busy still lasts DIV_LAT cycles, mthi waits
    drive(1'b1, I_DIV);
    tick();
    busy_cycles = 0;
    leak = 1'b0;
    flush = 1'b1;
    drive(1'b0, I_DIV);
    for (int i = 0; i < 64 && hilo_busy; i++) begin
      busy_cycles++;
      if (in_valid && in_ready) leak = 1'b1;
      tick();
      if (i == 0) begin
        check("div_flush_valid", 32'(out_valid), 0);
        flush = 1'b0;
        drive(1'b1, I_MTHI);
      end else begin
        #1;
      end
    end
    check("div_busy_cycles", busy_cycles, 32);
    check("mthi_no_leak",    32'(leak), 0);
    check("mthi_ready",      32'(in_ready), 1);
    tick();
    check("mthi_valid", 32'(out_valid), 1);
    check("mthi_we",    32'(hilo_we), 1);
    drive(1'b0, I_MTHI);
    tick();

    // backpressure: bundle held stable, then replaced in one cycle
    out_ready = 1'b0;
    drive(1'b1, I_AND);
    tick();
    drive(1'b1, I_ORI);
    check("bp_in_ready", 32'(in_ready), 0);
    tick();
    check("bp_valid_1", 32'(out_valid), 1);
    check("bp_ctrl_1",  32'(ctrl), 32'h005);
    tick();
    check("bp_ctrl_2",  32'(ctrl), 32'h005);
    out_ready = 1'b1;
    #1;
    check("bp_ready_on", 32'(in_ready), 1);
    tick();
    check("replace_valid", 32'(out_valid), 1);
    check("replace_ctrl",  32'(ctrl), 32'h044);
    drive(1'b0, I_ORI);
    tick();
    check("replace_drain", 32'(out_valid), 0);

    // scoreboarded stream with random EX backpressure
    idx = 0;
    for (int c = 0; c < 200 && (idx < N_STREAM || out_valid); c++) begin
      out_ready = (idx >= N_STREAM) || ($urandom_range(0, 1) == 1);
      if (idx < N_STREAM) drive(1'b1, s_instr[idx]);
      else                drive(1'b0, '0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("sb_underflow", 1, 0);
        else check("sb_stream", 32'({ri, sign_ext, ctrl}), 32'(exp_q.pop_front()));
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(s_exp[idx]);
        idx++;
      end
      tick();
    end
    drive(1'b0, '0);
    out_ready = 1'b1;
    check("sb_issued",  idx, N_STREAM);
    check("sb_drained", exp_q.size(), 0);

    // async reset mid-div (cnt=17) with a live bundle
    drive(1'b1, I_DIV);
    tick();
    drive(1'b0, I_DIV);
    repeat (14) tick();
    drive(1'b1, I_AND);
    tick();
    drive(1'b0, I_AND);
    check("pre_rst_valid", 32'(out_valid), 1);
    check("pre_rst_busy",  32'(hilo_busy), 1);
    #1 resetn = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 0);
    check("async_rst_busy",  32'(hilo_busy), 0);
    check("async_rst_ctrl",  32'(ctrl), 0);
    tick();
    resetn = 1'b1;
    drive(1'b1, I_MFHI);
    check("post_rst_ready", 32'(in_ready), 1);
    tick();
    check("post_rst_valid", 32'(out_valid), 1);
    check("post_rst_re",    32'(hilo_re), 1);
    drive(1'b0, I_MFHI);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
